row_mac_sequencer: RTL

- Per-row engine driven by the main calculation controller through begin_mult, res_add and done_row.
- For one row, it reads NUM_COLS coefficient/vector pairs from the shared SRAM port and multiply-accumulates them.
- The result is saturated and written back to the result region, then done_row is pulsed.
- It owns the only master port onto the matrix SRAM during calculation.

---
 rtl/main_calc_pkg.sv | 38 +++
 rtl/mac_unit.sv | 43 ++++
 rtl/row_mac_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/main_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_calc_pkg
// Purpose  : Shared sequencer state encoding, address bases and saturation.
// Revision : 1.0
// ============================================================================
package main_calc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_X = 3'd2,
    MAC  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } seq_state_t;

  localparam int C_NUM_COLS = 10;
  localparam int C_DATA_W   = 16;
  localparam int C_ADDR_W   = 10;
  localparam int C_BASE_A   = 0;
  localparam int C_BASE_X   = 100;
  localparam int C_BASE_R   = 120;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_unit
// Purpose  : Signed multiply-accumulate with a saturated DATA_W view of acc.
// Revision : 1.0
// ============================================================================
module mac_unit
  import main_calc_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int ACC_W  = 2 * C_DATA_W + 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_x,
  output logic        [DATA_W-1:0] o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod     = (2 * DATA_W)'(i_a) * (2 * DATA_W)'(i_x);
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // The accumulator is never seen unsaturated outside this block.
  assign o_acc = DATA_W'(sat_clamp(64'(r_acc), DATA_W));

endmodule
`default_nettype wire

// File: rtl/row_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : row_mac_sequencer
// Purpose  : Reads one matrix row and the vector, MACs them, writes sat(row).
// Revision : 1.0
// ============================================================================
module row_mac_sequencer
  import main_calc_pkg::*;
#(
  parameter int NUM_COLS = C_NUM_COLS,
  parameter int DATA_W   = C_DATA_W,
  parameter int ADDR_W   = C_ADDR_W,
  parameter int BASE_A   = C_BASE_A,
  parameter int BASE_X   = C_BASE_X,
  parameter int BASE_R   = C_BASE_R
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              begin_mult,
  input  logic [3:0]        res_add,
  output logic              done_row,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ACC_W = 2 * DATA_W + 4;

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [3:0]        r_row;
  logic [COL_W-1:0]  r_col;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_x;

  logic              w_start;
  logic              w_cap_a;
  logic              w_cap_x;
  logic              w_mac_en;
  logic              w_col_inc;
  logic              w_last_col;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_x;
  logic [ADDR_W-1:0] w_addr_r;
  logic [DATA_W-1:0] w_acc_sat;

  // Address arithmetic deliberately wraps at 2^ADDR_W.
  assign w_addr_a   = ADDR_W'(BASE_A) + ADDR_W'(r_row) * ADDR_W'(NUM_COLS) + ADDR_W'(r_col);
  assign w_addr_x   = ADDR_W'(BASE_X) + ADDR_W'(r_col);
  assign w_addr_r   = ADDR_W'(BASE_R) + ADDR_W'(r_row);
  assign w_last_col = (r_col == COL_W'(NUM_COLS - 1));
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done_row    = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_start     = 1'b0;
    w_cap_a     = 1'b0;
    w_cap_x     = 1'b0;
    w_mac_en    = 1'b0;
    w_col_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (begin_mult) begin
          w_start     = 1'b1;
          w_state_nxt = RD_A;
        end
      end
      RD_A: begin
        mem_ren  = 1'b1;
        mem_addr = w_addr_a;
        if (mem_ack) begin
          w_cap_a     = 1'b1;
          w_state_nxt = RD_X;
        end
      end
      RD_X: begin
        mem_ren  = 1'b1;
        mem_addr = w_addr_x;
        if (mem_ack) begin
          w_cap_x     = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (w_last_col) begin
          w_state_nxt = WR;
        end else begin
          w_col_inc   = 1'b1;
          w_state_nxt = RD_A;
        end
      end
      WR: begin
        mem_wen   = 1'b1;
        mem_addr  = w_addr_r;
        mem_wdata = w_acc_sat;
        if (mem_ack) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done_row    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_row <= '0;
      r_col <= '0;
      r_a   <= '0;
      r_x   <= '0;
    end else begin
      if (w_start) begin
        r_row <= res_add;
        r_col <= '0;
      end
      if (w_col_inc) begin
        r_col <= r_col + COL_W'(1);
      end
      if (w_cap_a) begin
        r_a <= mem_rdata;
      end
      if (w_cap_x) begin
        r_x <= mem_rdata;
      end
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .n_reset (n_reset),
    .i_clear (w_start),
    .i_en    (w_mac_en),
    .i_a     (r_a),
    .i_x     (r_x),
    .o_acc   (w_acc_sat)
  );

endmodule
`default_nettype wire
